fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Sits directly downstream of the radix-2^2 SDF FFT.
- Consumes the FFT's bit-reversed output stream (the sync/valid flag, the bin index and re/im data) and re-emits each frame in natural bin order 0..N-1.
- Uses a ping-pong pair of N-deep RAM banks: one bank is written while the other is read out, so back-to-back frames stream with no gap.
- Feeds the downstream magnitude/peak-detect and host-transfer logic.

Parameters:
- OW, 14, data width of re/im samples in and out.
- FFT_NLOG2, 10, log2 of FFT length.
- FFT_N, 1024, FFT length (must equal 2**FFT_NLOG2).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- valid_i  in  1  FFT output valid (driven from FFT sync_o); high continuously while a frame streams.
- idx_i  in  FFT_NLOG2  bin index of current input sample (bit-reversed sequence).
- re_i  in  OW  signed real part.
- im_i  in  OW  signed imaginary part.
- valid_o  out  1  output sample valid.
- sof_o  out  1  high with output bin 0 of each frame.
- idx_o  out  FFT_NLOG2  natural-order bin index of output sample.
- re_o  out  OW  signed real part, natural order.
- im_o  out  OW  signed imaginary part, natural order.
- err_o  out  1  sticky: idx_i differed from expected bit-reversed sequence.

Behaviour:
- Reset state, all synchronous to clk_i: valid_o=0, sof_o=0, idx_o=0, re_o=0, im_o=0, err_o=0, wr_cnt=0, wr_bank=0, read FSM=IDLE. RAM contents are not reset.
- Write side:
  - Each cycle with valid_i=1, store {re_i,im_i} at address idx_i of bank wr_bank, then increment wr_cnt.
  - Expected index is bitrev(wr_cnt). If idx_i != bitrev(wr_cnt), set err_o; the sample is still written at idx_i.
  - On valid_i=0, wr_cnt returns to 0 and the partial frame is discarded: no swap, no read. This mirrors the FFT restarting when its ce drops.
  - Frame completion is the cycle with valid_i=1 and wr_cnt=FFT_N-1. At that edge (E0): wr_cnt wraps to 0, wr_bank toggles, rd_bank <= old wr_bank, and the read FSM enters READ with rd_addr=0.
- Read FSM states:
  - IDLE: wait for frame completion.
  - READ: issue RAM read at rd_addr each cycle and increment it.
  - Leave READ after rd_addr=FFT_N-1 is issued. Go to IDLE unless a new completion occurs on that same edge; in that case restart READ at addr 0 on the new bank.
- A completion while READ is still mid-frame cannot occur with valid_i continuous, since write and read rates are equal. If it does occur (malformed stream), restart the read on the new bank and set err_o.
- RAM read is synchronous (1 cycle); outputs are registered (1 cycle).
- Latency: output bin k of a frame appears at edge E0+2+k. valid_o is high for FFT_N consecutive cycles per frame, and sof_o is high together with idx_o=0.
- idx_o equals the read address delayed by 2 cycles; re_o/im_o are RAM data, passed through unchanged with no rounding or width change.
- Back-to-back frames: bin FFT_N-1 of frame n is immediately followed by bin 0 of frame n+1, with no valid_o gap.
- Reset mid-operation: the next edge forces the reset state. valid_o drops that cycle, any in-flight read is abandoned, and the partially written frame is discarded.
- err_o clears only on rst_i.

Decomposition:
- Shared fmcw defines/params header: OW, FFT_NLOG2, FFT_N, plus a bitrev function usable by both this block and the bench.
- Sub-module fft_bitrev_bank_ram: simple dual-port RAM, depth 2*FFT_N, width 2*OW, 1-cycle registered read, address {bank,addr}, inferable as block RAM.
- The control FSM and counters stay in the top module.

Test Plan:
- Single frame: valid_i high for 1024 cycles, idx_i=bitrev(n), re_i=n, im_i=-n, then valid_i low → at E0+2+k: valid_o=1, idx_o=k, re_o=bitrev(k), im_o=-bitrev(k) for k=0..1023; sof_o only at k=0; err_o=0; valid_o low afterwards.
- Back-to-back: 3 continuous frames with re_i=frame_id*1024+n → 3072 consecutive valid_o cycles, each frame correctly reordered, sof_o at cycles 0/1024/2048, no gap.
- Partial frame: valid_i high 500 cycles then low 5, then a full frame → only the full frame emitted (1024 valid_o), and it contains no partial-frame data.
- Index error: at n=37 drive idx_i=0 instead of bitrev(37) → err_o rises the following cycle and stays high through the end of the frame.
- Reset mid-readout: assert rst_i at output bin 300 for one cycle → valid_o=0 on the next edge, no further outputs, err_o=0. A subsequent full frame reorders correctly starting from bank 0.
- Boundary values: re_i=+8191/-8192, im_i=-8192/+8191 at bins 0 and 1023 → identical values at idx_o 0 and 1023, with no sign or width corruption.

Source files
------------

// File: rtl/fft_bitrev_reorder_pkg.sv
// rtl/fft_bitrev_reorder_pkg.sv - shared FFT reorder parameters, types and bit-reverse helper
//
// Purpose : common widths for the FFT output reorder path, the read-side
//           state type and a bit-reverse function shared by RTL and bench.
// Ports   : none (package).

package fft_bitrev_reorder_pkg;

   localparam int OW_C        = 14;
   localparam int FFT_NLOG2_C = 10;
   localparam int FFT_N_C     = 1 << FFT_NLOG2_C;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_e;

   // Mirror the index bits: bit i of the result is bit (N-1-i) of a.
   function automatic logic [FFT_NLOG2_C-1:0] bitrev(input logic [FFT_NLOG2_C-1:0] a);
      logic [FFT_NLOG2_C-1:0] r;
      r = '0;
      for (int i = 0; i < FFT_NLOG2_C; i++) begin
         r[i] = a[FFT_NLOG2_C-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_bank_ram.sv
// rtl/fft_bitrev_bank_ram.sv - ping-pong bank storage, simple dual-port, registered read
//
// Purpose : 2*FFT_N x 2*OW simple dual-port RAM holding both ping-pong
//           banks; address MSB selects the bank. One write port, one read
//           port with a 1-cycle registered read, written to infer block RAM.
// Ports   : clk_i     - clock
//           wr_en_i   - write strobe
//           wr_addr_i - write address {bank, addr}
//           wr_data_i - write data {re, im}
//           rd_en_i   - read strobe
//           rd_addr_i - read address {bank, addr}
//           rd_data_o - read data, valid the cycle after rd_en_i

module fft_bitrev_bank_ram #(
   parameter int AW = 11,
   parameter int DW = 28
) (
   input  logic          clk_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);

   localparam int DEPTH = 1 << AW;

   // Contents are deliberately not reset so the array maps onto block RAM.
   logic [DW-1:0] mem_q [0:DEPTH-1];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - reorders bit-reversed FFT output frames into natural bin order
//
// Purpose : writes each incoming sample at its bin index in one bank while
//           the other bank is read out sequentially, giving gapless
//           natural-order frames two cycles after the frame completes.
// Ports   : clk_i   - clock
//           rst_i   - synchronous active-high reset
//           valid_i - input valid, continuous during a frame
//           idx_i   - input bin index (bit-reversed sequence)
//           re_i    - input real part (signed)
//           im_i    - input imaginary part (signed)
//           valid_o - output valid
//           sof_o   - high with bin 0 of each output frame
//           idx_o   - output bin index (natural order)
//           re_o    - output real part
//           im_o    - output imaginary part
//           err_o   - sticky stream error flag

module fft_bitrev_reorder
   import fft_bitrev_reorder_pkg::*;
#(
   parameter int OW        = OW_C,
   parameter int FFT_NLOG2 = FFT_NLOG2_C,
   parameter int FFT_N     = FFT_N_C
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   input  logic [FFT_NLOG2-1:0] idx_i,
   input  logic [OW-1:0]        re_i,
   input  logic [OW-1:0]        im_i,
   output logic                 valid_o,
   output logic                 sof_o,
   output logic [FFT_NLOG2-1:0] idx_o,
   output logic [OW-1:0]        re_o,
   output logic [OW-1:0]        im_o,
   output logic                 err_o
);

   localparam logic [FFT_NLOG2-1:0] LAST_IDX = FFT_NLOG2'(FFT_N - 1);

   // write side
   logic [FFT_NLOG2-1:0] wr_cnt_q, wr_cnt_d;
   logic                 wr_bank_q;

   // read side
   rd_state_e            rd_state_q;
   logic [FFT_NLOG2-1:0] rd_addr_q, rd_addr_d;
   logic                 rd_bank_q;

   // read pipeline stage aligned with RAM output
   logic                 s1_vld_q;
   logic [FFT_NLOG2-1:0] s1_idx_q;

   logic                 frame_done;
   logic                 idx_bad;
   logic                 rd_issue;
   logic                 rd_last;
   logic                 overrun;
   logic [2*OW-1:0]      ram_rdata;

   assign frame_done = valid_i && (wr_cnt_q == LAST_IDX);
   assign idx_bad    = valid_i && (idx_i != bitrev(wr_cnt_q));
   assign rd_issue   = (rd_state_q == RD_READ);
   assign rd_last    = rd_issue && (rd_addr_q == LAST_IDX);
   // A completion before the readout finished means the stream was malformed.
   assign overrun    = frame_done && rd_issue && !rd_last;

   always_comb begin
      wr_cnt_d  = '0;
      rd_addr_d = rd_addr_q;
      if (valid_i) begin
         // Counter width equals log2(N), so the last sample wraps it to 0.
         wr_cnt_d = wr_cnt_q + 1'b1;
      end
      if (frame_done) begin
         rd_addr_d = '0;
      end else if (rd_issue) begin
         rd_addr_d = rd_addr_q + 1'b1;
      end
   end

   fft_bitrev_bank_ram #(
      .AW (FFT_NLOG2 + 1),
      .DW (2 * OW)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (valid_i),
      .wr_addr_i ({wr_bank_q, idx_i}),
      .wr_data_i ({re_i, im_i}),
      .rd_en_i   (rd_issue),
      .rd_addr_i ({rd_bank_q, rd_addr_q}),
      .rd_data_o (ram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_cnt_q   <= '0;
         wr_bank_q  <= 1'b0;
         rd_state_q <= RD_IDLE;
         rd_addr_q  <= '0;
         rd_bank_q  <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_idx_q   <= '0;
         valid_o    <= 1'b0;
         sof_o      <= 1'b0;
         idx_o      <= '0;
         re_o       <= '0;
         im_o       <= '0;
         err_o      <= 1'b0;
      end else begin
         wr_cnt_q  <= wr_cnt_d;
         rd_addr_q <= rd_addr_d;

         // A completion always (re)starts the readout on the just-filled bank,
         // including on the edge that issues the previous frame's last address.
         if (frame_done) begin
            wr_bank_q  <= ~wr_bank_q;
            rd_bank_q  <= wr_bank_q;
            rd_state_q <= RD_READ;
         end else if (rd_last) begin
            rd_state_q <= RD_IDLE;
         end

         if (idx_bad || overrun) begin
            err_o <= 1'b1;
         end

         s1_vld_q <= rd_issue;
         s1_idx_q <= rd_addr_q;

         valid_o <= s1_vld_q;
         sof_o   <= s1_vld_q && (s1_idx_q == '0);
         if (s1_vld_q) begin
            idx_o <= s1_idx_q;
            re_o  <= ram_rdata[2*OW-1:OW];
            im_o  <= ram_rdata[OW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - directed self-checking bench for fft_bitrev_reorder

module tb_fft_bitrev_reorder;
   import fft_bitrev_reorder_pkg::*;

   localparam int OW = 14;
   localparam int NL = 10;
   localparam int N  = 1024;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          valid_i;
   logic [NL-1:0] idx_i;
   logic [OW-1:0] re_i;
   logic [OW-1:0] im_i;
   logic          valid_o;
   logic          sof_o;
   logic [NL-1:0] idx_o;
   logic [OW-1:0] re_o;
   logic [OW-1:0] im_o;
   logic          err_o;

   typedef struct packed {
      logic          dc;
      logic [NL-1:0] idx;
      logic [OW-1:0] re;
      logic [OW-1:0] im;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   n_out    = 0;
   int   run_len  = 0;
   int   last_run = 0;
   int   o0;

   always #5 clk = ~clk;

   fft_bitrev_reorder #(.OW(OW), .FFT_NLOG2(NL), .FFT_N(N)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .idx_i   (idx_i),
      .re_i    (re_i),
      .im_i    (im_i),
      .valid_o (valid_o),
      .sof_o   (sof_o),
      .idx_o   (idx_o),
      .re_o    (re_o),
      .im_o    (im_o),
      .err_o   (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Sample value driven for sample n of a frame.
   function automatic logic [OW-1:0] samp_re(input int base, input int n, input bit bnd);
      if (bnd && n == 0)     return 14'sd8191;
      if (bnd && n == N - 1) return -14'sd8192;
      return OW'(base + n);
   endfunction

   function automatic logic [OW-1:0] samp_im(input int base, input int n, input bit bnd);
      if (bnd && n == 0)     return -14'sd8192;
      if (bnd && n == N - 1) return 14'sd8191;
      return OW'(-(base + n));
   endfunction

   // Drives len samples with valid_i high (left high on return), starting and
   // ending at posedge+1. With push set, queues the natural-order frame.
   task automatic drive_frame(input int base, input int len, input int bad_n,
                              input bit bnd, input bit push);
      exp_t e;
      int   n;
      for (int i = 0; i < len; i++) begin
         valid_i = 1'b1;
         idx_i   = (i == bad_n) ? '0 : bitrev(NL'(i));
         re_i    = samp_re(base, i, bnd);
         im_i    = samp_im(base, i, bnd);
         if (i == bad_n) chk("err_before_bad_idx", 32'(err_o), 32'd0);
         @(posedge clk); #1;
         if (i == bad_n) chk("err_after_bad_idx", 32'(err_o), 32'd1);
      end
      if (push) begin
         for (int k = 0; k < N; k++) begin
            n     = int'(bitrev(NL'(k)));
            e.dc  = 1'b0;
            e.idx = NL'(k);
            e.re  = samp_re(base, n, bnd);
            e.im  = samp_im(base, n, bnd);
            if (bad_n >= 0) begin
               // The misplaced sample overwrote bin 0; its own bin holds stale data.
               if (k == 0) begin
                  e.re = samp_re(base, bad_n, bnd);
                  e.im = samp_im(base, bad_n, bnd);
               end
               if (k == int'(bitrev(NL'(bad_n)))) e.dc = 1'b1;
            end
            exp_q.push_back(e);
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (valid_o) begin
         run_len++;
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(valid_o), 32'd0);
         end else begin
            e = exp_q.pop_front();
            n_out++;
            chk("idx_o", 32'(idx_o), 32'(e.idx));
            chk("sof_o", 32'(sof_o), 32'(e.idx == '0));
            if (!e.dc) begin
               chk("re_o", 32'(re_o), 32'(e.re));
               chk("im_o", 32'(im_o), 32'(e.im));
            end
         end
      end else begin
         if (run_len != 0) last_run = run_len;
         run_len = 0;
      end
   end

   task automatic drain_and_check(input string tag, input int base_cnt, input int exp_cnt,
                                  input int exp_run);
      repeat (N + 40) @(posedge clk);
      #1;
      chk({tag, "_count"}, 32'(n_out - base_cnt), 32'(exp_cnt));
      chk({tag, "_run"}, 32'(last_run), 32'(exp_run));
      chk({tag, "_valid_low"}, 32'(valid_o), 32'd0);
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_i   = 1'b1;
      valid_i = 1'b0;
      idx_i   = '0;
      re_i    = '0;
      im_i    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_sof_o", 32'(sof_o), 32'd0);
      chk("rst_idx_o", 32'(idx_o), 32'd0);
      chk("rst_re_o", 32'(re_o), 32'd0);
      chk("rst_im_o", 32'(im_o), 32'd0);
      chk("rst_err_o", 32'(err_o), 32'd0);
      rst_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // single frame
      o0 = n_out;
      drive_frame(0, N, -1, 1'b0, 1'b1);
      valid_i = 1'b0;
      drain_and_check("single", o0, N, N);
      chk("single_err", 32'(err_o), 32'd0);

      // full-scale values at bins 0 and N-1
      o0 = n_out;
      drive_frame(0, N, -1, 1'b1, 1'b1);
      valid_i = 1'b0;
      drain_and_check("boundary", o0, N, N);

      // three back-to-back frames
      o0 = n_out;
      for (int f = 0; f < 3; f++) drive_frame(f * N, N, -1, 1'b0, 1'b1);
      valid_i = 1'b0;
      drain_and_check("b2b", o0, 3 * N, 3 * N);
      chk("b2b_err", 32'(err_o), 32'd0);

      // partial frame is discarded, full frame follows
      o0 = n_out;
      drive_frame(5000, 500, -1, 1'b0, 1'b0);
      valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      drive_frame(100, N, -1, 1'b0, 1'b1);
      valid_i = 1'b0;
      drain_and_check("partial", o0, N, N);
      chk("partial_err", 32'(err_o), 32'd0);

      // wrong index at sample 37
      o0 = n_out;
      drive_frame(200, N, 37, 1'b0, 1'b1);
      valid_i = 1'b0;
      chk("err_held_frame_end", 32'(err_o), 32'd1);
      drain_and_check("idxerr", o0, N, N);
      chk("err_sticky", 32'(err_o), 32'd1);

      // reset while bin 300 is on the output
      o0 = n_out;
      drive_frame(300, N, -1, 1'b0, 1'b1);
      valid_i = 1'b0;
      repeat (302) @(posedge clk);
      #1;
      chk("pre_rst_idx_o", 32'(idx_o), 32'd300);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      exp_q.delete();
      chk("midrst_valid_o", 32'(valid_o), 32'd0);
      chk("midrst_sof_o", 32'(sof_o), 32'd0);
      chk("midrst_err_o", 32'(err_o), 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("midrst_count", 32'(n_out - o0), 32'd301);
      chk("midrst_valid_low", 32'(valid_o), 32'd0);

      // fresh frame after reset
      o0 = n_out;
      drive_frame(400, N, -1, 1'b0, 1'b1);
      valid_i = 1'b0;
      drain_and_check("post_rst", o0, N, N);
      chk("post_rst_err", 32'(err_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
